// File: rtl/gpio_input_debounce.sv
// Board input conditioner: per-channel 2-FF synchronizer, counter debounce
// filter and registered rise/fall edge pulses feeding the SoC GPIO input bus.
module gpio_input_debounce #(
    parameter int                N_CH            = 8,
    parameter int                DEBOUNCE_CYCLES = 500000,
    parameter logic [N_CH-1:0]   RST_VAL         = {N_CH{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] raw_i,
    output logic [N_CH-1:0] clean_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic            changed_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
        $error("gpio_input_debounce: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [N_CH-1:0]  sync1_r;
    logic [N_CH-1:0]  sync2_r;
    logic [CNT_W-1:0] cnt_r      [N_CH];
    logic [CNT_W-1:0] cnt_nxt_s  [N_CH];
    logic [N_CH-1:0]  clean_nxt_s;
    logic [N_CH-1:0]  rise_nxt_s;
    logic [N_CH-1:0]  fall_nxt_s;
    logic             changed_nxt_s;

    // Next-state filter: count consecutive mismatching cycles, accept the new level at the terminal count.
    always_comb begin
        clean_nxt_s = clean_o;
        rise_nxt_s  = {N_CH{1'b0}};
        fall_nxt_s  = {N_CH{1'b0}};
        cnt_nxt_s   = cnt_r;
        for (int i = 0; i < N_CH; i++) begin
            if (sync2_r[i] == clean_o[i]) begin
                cnt_nxt_s[i] = {CNT_W{1'b0}};
            end else if (cnt_r[i] == CNT_LAST) begin
                // The pulse is registered on the same edge as the new level.
                clean_nxt_s[i] = sync2_r[i];
                rise_nxt_s[i]  = sync2_r[i];
                fall_nxt_s[i]  = ~sync2_r[i];
                cnt_nxt_s[i]   = {CNT_W{1'b0}};
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
        changed_nxt_s = |(rise_nxt_s | fall_nxt_s);
    end

    // State and output registers; async reset forces the configured idle levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r   <= RST_VAL;
            sync2_r   <= RST_VAL;
            clean_o   <= RST_VAL;
            rise_o    <= {N_CH{1'b0}};
            fall_o    <= {N_CH{1'b0}};
            changed_o <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            sync1_r   <= raw_i;
            sync2_r   <= sync1_r;
            clean_o   <= clean_nxt_s;
            rise_o    <= rise_nxt_s;
            fall_o    <= fall_nxt_s;
            changed_o <= changed_nxt_s;
            for (int i = 0; i < N_CH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

endmodule

// File: tb/tb_gpio_input_debounce.sv
// Directed bench for gpio_input_debounce with DEBOUNCE_CYCLES=4, plus an
// RST_VAL=8'h80 instance and a single-channel DEBOUNCE_CYCLES=1 instance.
module tb_gpio_input_debounce;

    logic       clk;
    logic       rst;
    logic       rst_v;
    logic [7:0] raw;
    logic [7:0] raw_v;
    logic [0:0] raw_d1;
    logic [7:0] clean, rise, fall;
    logic       changed;
    logic [7:0] clean_v, rise_v, fall_v;
    logic       changed_v;
    logic [0:0] clean_d1, rise_d1, fall_d1;
    logic       changed_d1;

    int n_checks = 0;
    int n_errors = 0;

    gpio_input_debounce #(.N_CH(8), .DEBOUNCE_CYCLES(4), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .raw_i(raw),
        .clean_o(clean), .rise_o(rise), .fall_o(fall), .changed_o(changed)
    );

    gpio_input_debounce #(.N_CH(8), .DEBOUNCE_CYCLES(4), .RST_VAL(8'h80)) dut_v (
        .clk(clk), .rst(rst_v), .raw_i(raw_v),
        .clean_o(clean_v), .rise_o(rise_v), .fall_o(fall_v), .changed_o(changed_v)
    );

    gpio_input_debounce #(.N_CH(1), .DEBOUNCE_CYCLES(1), .RST_VAL(1'b0)) dut_d1 (
        .clk(clk), .rst(rst), .raw_i(raw_d1),
        .clean_o(clean_d1), .rise_o(rise_d1), .fall_o(fall_d1), .changed_o(changed_d1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 8'h%02h, expected 8'h%02h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        rst_v  = 1'b1;
        raw    = 8'h00;
        raw_v  = 8'h00;
        raw_d1 = 1'b0;
        step(2);
        check("reset_clean", clean, 8'h00);
        check("reset_changed", 8'(changed), 8'h00);
        check("reset_v_clean", clean_v, 8'h80);

        // Drive all-ones, let it settle, then hit reset mid-cycle while rise is high.
        rst = 1'b0;
        raw = 8'hFF;
        step(5);
        check("ff_before", clean, 8'h00);
        step(1);
        check("ff_clean", clean, 8'hFF);
        check("ff_rise", rise, 8'hFF);
        check("ff_changed", 8'(changed), 8'h01);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_clean", clean, 8'h00);
        check("async_rst_rise", rise, 8'h00);
        check("async_rst_fall", fall, 8'h00);
        check("async_rst_changed", 8'(changed), 8'h00);
        step(2);
        check("rst_hold_clean", clean, 8'h00);
        rst = 1'b0;
        raw = 8'h00;
        step(3);
        check("post_rst_clean", clean, 8'h00);
        check("post_rst_changed", 8'(changed), 8'h00);

        // Clean press on channel 0.
        raw = 8'h01;
        step(5);
        check("press_k4_clean", clean, 8'h00);
        check("press_k4_fall", fall, 8'h00);
        step(1);
        check("press_clean", clean, 8'h01);
        check("press_rise", rise, 8'h01);
        check("press_changed", 8'(changed), 8'h01);
        check("press_fall", fall, 8'h00);
        step(1);
        check("press_rise_end", rise, 8'h00);
        check("press_changed_end", 8'(changed), 8'h00);
        check("press_clean_hold", clean, 8'h01);

        // Bounce on channel 1: 3-cycle phases never reach the terminal count.
        for (int p = 0; p < 4; p++) begin
            raw = (p % 2 == 0) ? 8'h03 : 8'h01;
            step(3);
            check("bounce_clean", clean, 8'h01);
            check("bounce_rise", rise, 8'h00);
        end
        raw = 8'h03;
        step(5);
        check("bounce_k4_clean", clean, 8'h01);
        step(1);
        check("bounce_clean_up", clean, 8'h03);
        check("bounce_rise", rise, 8'h02);
        for (int c = 0; c < 4; c++) begin
            step(1);
            check("bounce_single", rise, 8'h00);
        end

        // Release ch0 and press ch4 on the same capture edge.
        raw = 8'h12;
        step(5);
        check("simul_k4_clean", clean, 8'h03);
        check("simul_k4_changed", 8'(changed), 8'h00);
        step(1);
        check("simul_clean", clean, 8'h12);
        check("simul_fall", fall, 8'h01);
        check("simul_rise", rise, 8'h10);
        check("simul_changed", 8'(changed), 8'h01);
        step(1);
        check("simul_changed_end", 8'(changed), 8'h00);
        check("simul_fall_end", fall, 8'h00);
        check("simul_rise_end", rise, 8'h00);

        // Reset in the middle of a ch2 count.
        raw = 8'h16;
        step(4);
        rst = 1'b1;
        #2;
        check("midcnt_clean", clean, 8'h00);
        check("midcnt_rise", rise, 8'h00);
        rst = 1'b0;
        step(5);
        check("midcnt_k4_clean", clean, 8'h00);
        check("midcnt_k4_rise", rise, 8'h00);
        step(1);
        check("midcnt_clean_up", clean, 8'h16);
        check("midcnt_rise_up", rise, 8'h16);
        check("midcnt_changed", 8'(changed), 8'h01);

        // RST_VAL=8'h80 instance: ch7 low through release falls after debounce.
        rst_v = 1'b0;
        #1;
        check("v_release_clean", clean_v, 8'h80);
        step(5);
        check("v_k4_clean", clean_v, 8'h80);
        check("v_k4_fall", fall_v, 8'h00);
        step(1);
        check("v_clean", clean_v, 8'h00);
        check("v_fall", fall_v, 8'h80);
        check("v_rise", rise_v, 8'h00);
        check("v_changed", 8'(changed_v), 8'h01);
        step(1);
        check("v_fall_end", fall_v, 8'h00);

        // DEBOUNCE_CYCLES=1: follows sync2 one edge after the first mismatch.
        raw_d1 = 1'b1;
        step(2);
        check("d1_k1_clean", 8'(clean_d1), 8'h00);
        step(1);
        check("d1_clean", 8'(clean_d1), 8'h01);
        check("d1_rise", 8'(rise_d1), 8'h01);
        step(1);
        check("d1_rise_end", 8'(rise_d1), 8'h00);
        raw_d1 = 1'b0;
        step(3);
        check("d1_fall_clean", 8'(clean_d1), 8'h00);
        check("d1_fall", 8'(fall_d1), 8'h01);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
